// File: rtl/regfile_read_arbiter.sv
// regfile_read_arbiter: round-robin share of one register-file read port among NUM_REQ requesters
module regfile_read_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic                      hold,
  input  logic [DATA_W-1:0]         rd_data,
  output logic [ADDR_W-1:0]         sel,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         data_out,
  output logic [NUM_REQ-1:0]        valid
);
  localparam int PTR_W = $clog2(NUM_REQ);
  logic [PTR_W-1:0]   ptr, w, idx;
  logic [NUM_REQ-1:0] elig;
  logic               found, take;
  // Scan downwards so the requester closest to ptr is the last (winning) assignment.
  always_comb begin
    elig  = req & ~gnt & ~valid;
    w     = '0;
    idx   = '0;
    found = 1'b0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + PTR_W'(k);
      if (elig[idx]) begin
        w     = idx;
        found = 1'b1;
      end
    end
    take = found & ~hold;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= '0;
      gnt      <= '0;
      data_out <= '0;
      valid    <= '0;
      ptr      <= '0;
    end else begin
      valid    <= gnt;
      data_out <= |gnt ? rd_data : data_out;
      gnt      <= take ? {{(NUM_REQ-1){1'b0}}, 1'b1} << w : '0;
      sel      <= take ? addr[int'(w)*ADDR_W +: ADDR_W] : sel;
      ptr      <= take ? w + PTR_W'(1) : ptr;
    end
  end
endmodule

// File: tb/tb_regfile_read_arbiter.sv
// tb_regfile_read_arbiter: directed and random stimulus checked against an integer-level model
module tb_regfile_read_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [19:0] addr = '0;
  logic        hold = 1'b0;
  logic [31:0] rd_data;
  logic [4:0]  sel;
  logic [3:0]  gnt, valid;
  logic [31:0] data_out;
  int n_vec = 0, n_err = 0;
  int m_gnt, m_valid, m_ptr;
  logic [4:0]  m_sel;
  logic [31:0] m_data;

  regfile_read_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req), .addr(addr), .hold(hold),
    .rd_data(rd_data), .sel(sel), .gnt(gnt), .data_out(data_out), .valid(valid)
  );

  assign rd_data = 32'hA000_0000 + 32'(sel);
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] onehot(input int i);
    return i < 0 ? 4'b0 : 4'(1 << i);
  endfunction

  task automatic model_reset();
    m_gnt = -1; m_valid = -1; m_ptr = 0; m_sel = '0; m_data = '0;
  endtask

  // Model one clock edge from the inputs currently driven, then compare after the edge.
  task automatic step();
    int nxt = -1;
    if (!hold)
      for (int k = 0; k < 4; k++) begin
        int i = (m_ptr + k) % 4;
        if (nxt < 0 && req[i] && i != m_gnt && i != m_valid) nxt = i;
      end
    m_valid = m_gnt;
    if (m_gnt >= 0) m_data = 32'hA000_0000 + 32'(m_sel);
    m_gnt = nxt;
    if (nxt >= 0) begin
      m_sel = addr[nxt*5 +: 5];
      m_ptr = (nxt + 1) % 4;
    end
    @(posedge clk);
    #1;
    chk("gnt", 32'(gnt), 32'(onehot(m_gnt)));
    chk("valid", 32'(valid), 32'(onehot(m_valid)));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("data_out", data_out, m_data);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_gnt"}, 32'(gnt), 0);
    chk({tag, "_valid"}, 32'(valid), 0);
    chk({tag, "_sel"}, 32'(sel), 0);
    chk({tag, "_data"}, data_out, 0);
  endtask

  initial begin
    model_reset();
    #2;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    // Single read from requester 2 at address 7.
    addr[14:10] = 5'd7;
    req = 4'b0100;
    step();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_sel", 32'(sel), 32'd7);
    req = 4'b0000;
    step();
    chk("single_valid", 32'(valid), 32'h4);
    chk("single_data", data_out, 32'hA000_0007);
    step();
    // All four requesting, ADDR[i]=i+1, each re-requesting after its VALID.
    for (int i = 0; i < 4; i++) addr[i*5 +: 5] = 5'(i + 1);
    req = 4'b1111;
    repeat (8) step();
    req = 4'b0000;
    repeat (2) step();
    // Lone requester 1: one read every 3 cycles.
    req = 4'b0010;
    repeat (7) step();
    // With ptr at 2, simultaneous 1011 -> 3, 0, 1.
    req = 4'b0000;
    repeat (2) step();
    req = 4'b0010;
    step();
    req = 4'b1011;
    repeat (4) step();
    req = 4'b0000;
    repeat (2) step();
    // HOLD while a read is in flight.
    req = 4'b0001;
    step();
    hold = 1'b1;
    req = 4'b1111;
    repeat (3) step();
    hold = 1'b0;
    repeat (3) step();
    req = 4'b0000;
    repeat (2) step();
    // Async reset while requester 2 is in flight.
    req = 4'b0100;
    step();
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    model_reset();
    #1;
    rst_n = 1'b1;
    req = 4'b0110;
    repeat (4) step();
    // Random traffic: requests held until their VALID, occasional early drop after grant.
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i] && m_valid == i) req[i] = 1'b0;
        else if (req[i] && m_gnt == i && $urandom_range(7) == 0) req[i] = 1'b0;
        else if (!req[i] && m_gnt != i && m_valid != i && $urandom_range(2) == 0) begin
          addr[i*5 +: 5] = 5'($urandom);
          req[i] = 1'b1;
        end
      end
      hold = $urandom_range(4) == 0;
      step();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_read_arbiter.md
Name: regfile_read_arbiter

Overview:
- Round-robin arbiter that shares one 32-bit, 32-entry register-file read port between 4 requesters.
- The read port is the 32x1 32-bit read mux, driven by a 5-bit select.
- Registers the winner's address onto the mux select, then captures the mux output one cycle later and returns it with a one-hot valid tag.
- Sits between the decode/operand-fetch requesters and the register-file read mux.

Parameters:
- NUM_REQ, 4, number of requesters; fixed at 4 for this revision.
- ADDR_W, 5, register address width; equals the read-mux select width.
- DATA_W, 32, read data width.

Ports:
- CLK  in  1  clock; all state updates on posedge.
- RST  in  1  asynchronous, active-low reset.
- REQ  in  4  per-requester read request level; held high until the matching VALID bit is seen.
- ADDR  in  20  packed addresses; requester i uses ADDR[5i+4:5i]; stable while REQ[i]=1.
- HOLD  in  1  when 1, no new grant is issued; an in-flight read still completes.
- RD_DATA  in  32  combinational read-mux output for the current SEL.
- SEL  out  5  registered select to the read mux.
- GNT  out  4  registered one-hot grant; read in flight for that requester.
- DATA_OUT  out  32  registered read data.
- VALID  out  4  registered one-hot; DATA_OUT belongs to this requester this cycle.

Behaviour:
- Reset (RST=0, async): SEL=0, GNT=0, DATA_OUT=0, VALID=0, round-robin pointer PTR=0. No VALID is ever produced for a read in flight at reset.
- Eligibility per edge: ELIG = REQ & ~GNT & ~VALID. A requester is never re-granted while its read is in flight or its result is being presented.
- Grant stage, each posedge:
  - If HOLD=0 and ELIG!=0: winner w is the first set bit of ELIG scanning PTR, PTR+1, ... mod 4.
  - Then GNT <= onehot(w), SEL <= ADDR[w], PTR <= (w+1) mod 4.
  - Otherwise: GNT <= 0, SEL holds its value, PTR holds.
- Return stage, each posedge: VALID <= GNT. If GNT!=0, DATA_OUT <= RD_DATA; else DATA_OUT holds.
- Latency: request sampled at edge k is granted at k; VALID and DATA_OUT are presented after edge k+1.
- Throughput: up to one grant per cycle across requesters; at most one read per 3 cycles for a single requester.
- GNT and VALID are each one-hot or zero. GNT and VALID may both be nonzero in the same cycle only for different requesters.
- Requester dropping REQ after being granted: the read still completes and VALID still pulses.
- PTR wraps 3 -> 0.
- Reset asserted mid-operation clears GNT and VALID immediately. Arbitration resumes from PTR=0 at the first posedge after RST=1.

Test Plan:
- Single read: bench model RD_DATA = 32'hA000_0000 + SEL. REQ=4'b0100, ADDR[14:10]=7 at edge 0 -> after edge 0 GNT=0100, SEL=7; after edge 1 VALID=0100, DATA_OUT=32'hA000_0007, GNT=0.
- All four REQ held high from reset, ADDR[i]=i+1 -> grant order 0,1,2,3,0,1 on consecutive edges. VALID trails GNT by one cycle with DATA_OUT = A0000001, A0000002, ... in order.
- Only REQ[1] held high -> grants at edges 0, 3, 6. VALID=0010 after edges 1, 4, 7. No grant at edges 1, 2, 4, 5.
- PTR=2, REQ=4'b1011 simultaneous -> grant 3 first, then 0, then 1 (PTR wrap check).
- HOLD=1 with REQ=4'b1111 while GNT=0001 in flight -> VALID=0001 still pulses next cycle; GNT stays 0 while HOLD=1. The first grant after HOLD drops follows PTR.
- RST pulsed low while GNT=0100 -> GNT, VALID, SEL, DATA_OUT read 0 immediately. No VALID for the lost read. After release, the first grant goes to the lowest-index eligible requester (PTR=0).
